// File: rtl/window_scheduler.sv
// Frame sequencer for the 9-row line-buffer chain: forwards raster pixels, tags
// window centers with coordinates and a border flag, then injects zero flush rows.
module window_scheduler #(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int HALF  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     pix_valid_i,
    input  logic [7:0]               pix_i,
    output logic                     ready_o,
    output logic                     lb_valid_o,
    output logic [7:0]               lb_data_o,
    output logic                     lb_flush_o,
    output logic                     win_valid_o,
    output logic [$clog2(IMG_H)-1:0] row_o,
    output logic [$clog2(IMG_W)-1:0] col_o,
    output logic                     border_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int FW = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [RW-1:0] ROW_LO   = RW'(HALF);
    localparam logic [RW-1:0] ROW_HI   = RW'(IMG_H - 1 - HALF);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FILL = RW'(HALF - 1);
    localparam logic [RW-1:0] ROW_FLSH = RW'(IMG_H - HALF);
    localparam logic [CW-1:0] COL_LO   = CW'(HALF);
    localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - 1 - HALF);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(HALF - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] in_row;
    logic [CW-1:0] in_col;
    logic [FW-1:0] fl_row;

    logic          accept, col_last, row_last, flush_last;
    logic          beat_vld, beat_flush, win_nxt, border_nxt;
    logic [7:0]    beat_data;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    assign col_last   = (in_col == COL_LAST);
    assign row_last   = (in_row == ROW_LAST);
    assign flush_last = (fl_row == FL_LAST) && col_last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_i) state_nxt = S_FILL;
            S_FILL:   if (accept && col_last && in_row == ROW_FILL) state_nxt = S_STREAM;
            S_STREAM: if (accept && col_last && row_last) state_nxt = S_FLUSH;
            S_FLUSH:  if (flush_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic: handshake plus the beat that gets registered this edge
    always_comb begin
        ready_o    = (state == S_FILL) || (state == S_STREAM);
        busy_o     = (state != S_IDLE);
        accept     = pix_valid_i && ready_o;
        beat_vld   = 1'b0;
        beat_flush = 1'b0;
        beat_data  = 8'd0;
        win_nxt    = 1'b0;
        row_nxt    = '0;
        col_nxt    = '0;
        if (accept) begin
            beat_vld  = 1'b1;
            beat_data = pix_i;
            // Guarded so the center row never exposes a negative wrap
            if (in_row >= ROW_LO) begin
                win_nxt = 1'b1;
                row_nxt = in_row - ROW_LO;
                col_nxt = in_col;
            end
        end else if (state == S_FLUSH) begin
            beat_vld   = 1'b1;
            beat_flush = 1'b1;
            win_nxt    = 1'b1;
            row_nxt    = ROW_FLSH + RW'(fl_row);
            col_nxt    = in_col;
        end
        border_nxt = win_nxt && (row_nxt < ROW_LO || row_nxt > ROW_HI ||
                                 col_nxt < COL_LO || col_nxt > COL_HI);
    end

    // Position counters; in_col is reused as the flush column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_row <= '0;
            in_col <= '0;
            fl_row <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    in_row <= '0;
                    in_col <= '0;
                    fl_row <= '0;
                end
                S_FILL, S_STREAM: if (accept) begin
                    if (col_last) begin
                        in_col <= '0;
                        in_row <= row_last ? '0 : in_row + RW'(1);
                    end else begin
                        in_col <= in_col + CW'(1);
                    end
                end
                S_FLUSH: begin
                    if (col_last) begin
                        in_col <= '0;
                        fl_row <= fl_row + FW'(1);
                    end else begin
                        in_col <= in_col + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered beat outputs, one cycle behind the accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_valid_o  <= 1'b0;
            lb_data_o   <= 8'd0;
            lb_flush_o  <= 1'b0;
            win_valid_o <= 1'b0;
            row_o       <= '0;
            col_o       <= '0;
            border_o    <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            lb_valid_o  <= beat_vld;
            lb_data_o   <= beat_data;
            lb_flush_o  <= beat_flush;
            win_valid_o <= win_nxt;
            row_o       <= row_nxt;
            col_o       <= col_nxt;
            border_o    <= border_nxt;
            done_o      <= (state == S_FLUSH) && flush_last;
        end
    end

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler: frame runs with and without stalls,
// border map table, flush behaviour and mid-frame reset.
module tb_window_scheduler;

    localparam int W = 10;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       pix_valid_i = 1'b0;
    logic [7:0] pix_i = 8'd0;
    logic       ready_o, lb_valid_o, lb_flush_o, win_valid_o, border_o, busy_o, done_o;
    logic [7:0] lb_data_o;
    logic [$clog2(H)-1:0] row_o;
    logic [$clog2(W)-1:0] col_o;

    window_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i), .pix_i(pix_i),
        .ready_o(ready_o), .lb_valid_o(lb_valid_o), .lb_data_o(lb_data_o),
        .lb_flush_o(lb_flush_o), .win_valid_o(win_valid_o), .row_o(row_o), .col_o(col_o),
        .border_o(border_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        bit exp_border;
    } bvec_t;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    bit mon_clr = 1'b0;

    int n_acc, acc41, last_acc, n_lb, n_flush, n_real, n_win, n_done, done_cyc;
    int data_err, order_err, flush_err, stall_err, zero_err, first_win, n_b0;
    int fr, fc, fb;
    bit prev_ready, prev_acc;
    bit bmap[100];

    function automatic logic [7:0] pix_of(int i);
        return 8'(i * 37 + 11);
    endfunction

    task automatic chk(string name, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            n_acc = 0; acc41 = -1; last_acc = -1; n_lb = 0; n_flush = 0; n_real = 0;
            n_win = 0; n_done = 0; done_cyc = -1; data_err = 0; order_err = 0;
            flush_err = 0; stall_err = 0; zero_err = 0; first_win = -1; n_b0 = 0;
            fr = -1; fc = -1; fb = -1; prev_ready = 0; prev_acc = 0;
        end else if (!rst) begin
            if (prev_ready && (lb_valid_o != prev_acc)) stall_err++;
            if (lb_valid_o) begin
                n_lb++;
                if (lb_flush_o) begin
                    n_flush++;
                    if (lb_data_o != 8'd0 || ready_o) flush_err++;
                end else begin
                    if (n_flush != 0) flush_err++;
                    if (lb_data_o != pix_of(n_real)) data_err++;
                    n_real++;
                end
            end
            if (win_valid_o) begin
                if (n_win == 0) begin
                    first_win = cyc; fr = int'(row_o); fc = int'(col_o); fb = int'(border_o);
                end
                if (int'(row_o) != n_win / W || int'(col_o) != n_win % W) order_err++;
                if (n_win < 100) begin
                    bmap[n_win] = border_o;
                    if (!border_o) n_b0++;
                end
                n_win++;
            end else if (row_o != '0 || col_o != '0 || border_o) begin
                zero_err++;
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (pix_valid_i && ready_o) begin
                n_acc++;
                if (n_acc == 41) acc41 = cyc;
                last_acc = cyc;
            end
            prev_ready = ready_o;
            prev_acc   = pix_valid_i && ready_o;
        end
    end

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic feed(int n, int stall_pct, int start_at, output bit ok);
        int idx = 0;
        int budget = 0;
        bit acc;
        while (idx < n && budget < 3000) begin
            pix_valid_i = ($urandom_range(99) >= stall_pct);
            pix_i       = pix_of(idx);
            start_i     = (idx == start_at);
            acc         = pix_valid_i && ready_o;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        start_i = 1'b0;
        ok = (idx == n);
    endtask

    // Keep pix_valid_i high with junk data so flush must ignore it
    task automatic finish_frame(output bit ok);
        int b = 0;
        pix_valid_i = 1'b1;
        pix_i = 8'hAA;
        while (n_done == 0 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        pix_valid_i = 1'b0;
        pix_i = 8'd0;
        repeat (3) @(posedge clk);
        #1 ok = (n_done > 0);
    endtask

    function automatic int all_out();
        return int'({ready_o, lb_valid_o, lb_data_o, lb_flush_o, win_valid_o,
                     row_o, col_o, border_o, busy_o, done_o});
    endfunction

    initial begin
        bvec_t bv[6];
        bit ok;
        int bad;

        bv[0] = '{4, 4, 1'b0};
        bv[1] = '{4, 3, 1'b1};
        bv[2] = '{5, 6, 1'b1};
        bv[3] = '{6, 5, 1'b1};
        bv[4] = '{0, 0, 1'b1};
        bv[5] = '{5, 5, 1'b0};

        mon_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / idle behaviour
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", all_out(), 0);
        pix_valid_i = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (lb_valid_o || ready_o) bad++;
        end
        pix_valid_i = 1'b0;
        chk("idle_ignores_pixels", bad, 0);

        // Frame 1: no stalls
        mon_clear();
        start_frame();
        feed(100, 0, -1, ok);
        chk("f1_feed_done", int'(ok), 1);
        finish_frame(ok);
        chk("f1_done_seen", int'(ok), 1);
        chk("f1_accepts", n_acc, 100);
        chk("f1_lb_beats", n_lb, 140);
        chk("f1_win_beats", n_win, 100);
        chk("f1_first_win_lat", first_win - acc41, 1);
        chk("f1_first_win_row", fr, 0);
        chk("f1_first_win_col", fc, 0);
        chk("f1_first_win_border", fb, 1);
        chk("f1_done_count", n_done, 1);
        chk("f1_done_lat", done_cyc - last_acc, 41);
        chk("f1_data_err", data_err, 0);
        chk("f1_order_err", order_err, 0);
        chk("f1_flush_beats", n_flush, 40);
        chk("f1_flush_err", flush_err, 0);
        chk("f1_stall_err", stall_err, 0);
        chk("f1_zero_err", zero_err, 0);
        for (int i = 0; i < 6; i++)
            chk($sformatf("border_%0d_%0d", bv[i].r, bv[i].c),
                int'(bmap[bv[i].r * W + bv[i].c]), int'(bv[i].exp_border));
        chk("border_zero_count", n_b0, 4);

        // Frame 2: ~50% stalls
        mon_clear();
        start_frame();
        feed(100, 50, -1, ok);
        chk("f2_feed_done", int'(ok), 1);
        finish_frame(ok);
        chk("f2_lb_beats", n_lb, 140);
        chk("f2_win_beats", n_win, 100);
        chk("f2_data_err", data_err, 0);
        chk("f2_order_err", order_err, 0);
        chk("f2_stall_err", stall_err, 0);
        chk("f2_flush_err", flush_err, 0);
        chk("f2_done_count", n_done, 1);

        // Mid-frame reset during row 6, start_i pulsed while busy
        mon_clear();
        start_frame();
        feed(61, 0, 30, ok);
        chk("mid_feed_done", int'(ok), 1);
        chk("mid_busy", int'(busy_o), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs_zero", all_out(), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("mid_no_done", n_done, 0);
        chk("mid_idle_after_reset", int'(busy_o), 0);

        // Frame 3 after reset, with start_i asserted mid-frame
        mon_clear();
        start_frame();
        feed(100, 30, 50, ok);
        chk("f3_feed_done", int'(ok), 1);
        finish_frame(ok);
        chk("f3_win_beats", n_win, 100);
        chk("f3_lb_beats", n_lb, 140);
        chk("f3_order_err", order_err, 0);
        chk("f3_data_err", data_err, 0);
        chk("f3_done_count", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/window_scheduler.md
Name: window_scheduler

Overview:
- Sequences the 9-row line-buffer preparation chain for one frame.
- Accepts a raster pixel stream and forwards it to the chain with a shift-enable.
- Tracks row and column position and tags each window center with its coordinates and a border flag.
- After the last real pixel, injects zero flush rows so the bottom 4 image rows reach the window center, then pulses done.

Parameters:
- IMG_W, 10, pixels per row; equals the line-buffer DEPTH; must be >= 9.
- IMG_H, 10, rows per frame; must be >= 5.
- HALF, 4, window half-size (9-row window, center is tap 4); fixed, not for override.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-high reset.
- start_i, input, 1, begin a frame; sampled only in IDLE.
- pix_valid_i, input, 1, pix_i holds a valid pixel.
- pix_i, input, 8, pixel data in raster order.
- ready_o, output, 1, scheduler accepts pixels this cycle.
- lb_valid_o, output, 1, shift-enable to the line-buffer chain.
- lb_data_o, output, 8, pixel into the chain (data_i of stage 0).
- lb_flush_o, output, 1, current lb beat is a synthetic zero flush pixel.
- win_valid_o, output, 1, window center at (row_o, col_o) is a real image pixel.
- row_o, output, $clog2(IMG_H), center row.
- col_o, output, $clog2(IMG_W), center column.
- border_o, output, 1, the 9x9 window around the center extends outside the image.
- busy_o, output, 1, high in every state except IDLE.
- done_o, output, 1, one-cycle end-of-frame pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; in_row, in_col and flush counter 0. An asserted reset aborts any frame; no done_o is produced for the aborted frame.
- States: IDLE, FILL, STREAM, FLUSH, DONE.
- IDLE:
  - ready_o=0.
  - start_i=1 -> FILL; counters cleared.
  - start_i is ignored in all other states.
- Accept condition: pix_valid_i && ready_o.
  - ready_o=1 in FILL and STREAM.
  - A cycle with no accept produces lb_valid_o=0 and win_valid_o=0 next cycle; counters hold.
- Per accept, outputs are registered with 1-cycle latency:
  - lb_valid_o=1, lb_data_o=pix_i, lb_flush_o=0.
  - win_valid_o=(in_row>=HALF); row_o=in_row-HALF; col_o=in_col.
- Counters:
  - in_col increments per accept and wraps IMG_W-1 -> 0.
  - On wrap, in_row increments.
  - FILL -> STREAM when in_row reaches HALF.
- Last pixel: the accept at in_row=IMG_H-1, in_col=IMG_W-1 -> FLUSH; ready_o drops in the same cycle the transition is registered.
- FLUSH:
  - One beat per cycle, unconditionally, for HALF*IMG_W beats.
  - Each beat: lb_valid_o=1, lb_data_o=0, lb_flush_o=1, win_valid_o=1.
  - Center coordinates continue from IMG_H-HALF, col 0, up to IMG_H-1, col IMG_W-1.
  - After the last beat -> DONE.
- DONE: done_o=1 for exactly one cycle -> IDLE.
- Border: whenever win_valid_o=1, border_o=1 if row_o<HALF, row_o>IMG_H-1-HALF, col_o<HALF, or col_o>IMG_W-1-HALF; otherwise 0.
- Whenever win_valid_o=0, row_o, col_o and border_o are 0.
- Per frame totals:
  - Exactly IMG_W*IMG_H win_valid_o beats.
  - Exactly (IMG_H+HALF)*IMG_W lb_valid_o beats.
- Arithmetic: counters are unsigned. Center row is computed only when in_row>=HALF; no negative wrap is ever exposed.

Test Plan:
- Reset state: rst pulse, then idle 5 cycles -> all outputs 0; pix_valid_i=1 with no start_i gives lb_valid_o=0.
- Full frame, defaults, pix_valid_i always 1:
  - lb_valid_o beats = 140.
  - First win_valid_o 1 cycle after the 41st accept, at (0,0) with border_o=1.
  - win_valid_o beats = 100.
  - done_o pulses once, 41 cycles after the last accept.
- Random stall, pix_valid_i ~50%:
  - Same lb_data_o sequence as the no-stall run.
  - row_o/col_o sequence 0..9 x 0..9 in raster order.
  - No beat issued on stalled cycles.
- Border map: center (4,4) -> border_o=0; (4,3), (5,6), (6,5) -> border_o=1; exactly 4 of 100 centers have border_o=0.
- Flush: the last 40 lb beats have lb_flush_o=1 and lb_data_o=0; ready_o=0 throughout FLUSH; pix_valid_i pulses during FLUSH are ignored.
- Mid-frame reset and re-start:
  - rst asserted during STREAM at row 6 -> next cycle all outputs 0 and no done_o.
  - start_i ignored while busy_o=1.
  - A new frame after reset completes with 100 win_valid_o beats.
